// File: rtl/pwm_update_scheduler.sv
// PWM update scheduler: shadows SPI config and commits it at period edges.
// Generates the shared PWM counter and the registered channel outputs.
module pwm_update_scheduler #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start,
  output logic        update_pending,
  output logic        running
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nx;
  logic [7:0]  pre_cnt, pre_nx;
  logic [7:0]  pwm_cnt, cnt_nx;
  logic [15:0] app_out, app_out_nx;
  logic [15:0] app_pwm, app_pwm_nx;
  logic [7:0]  app_duty, app_duty_nx;
  logic [15:0] out_nx;
  logic        ps_nx;
  logic [15:0] req_out, req_pwm;
  logic        tick, wrap, load, pwm_high;

  assign req_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign req_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  assign tick = (pre_cnt == 8'(PRESCALE - 1));
  assign wrap = (state == RUN) && tick && (pwm_cnt == 8'hFF);
  assign load = (state == IDLE) || wrap;

  assign pwm_high = (app_duty == 8'hFF) || (pwm_cnt < app_duty);

  assign running = (state == RUN);
  assign update_pending = running &&
    ({req_out, req_pwm, pwm_duty_cycle} !=
     {app_out, app_pwm, app_duty});

  // Next state, shadow load, counters and output pattern.
  always_comb begin
    state_nx    = state;
    app_out_nx  = app_out;
    app_pwm_nx  = app_pwm;
    app_duty_nx = app_duty;
    pre_nx      = 8'd0;
    cnt_nx      = 8'd0;
    if (load) begin
      app_out_nx  = req_out;
      app_pwm_nx  = req_pwm;
      app_duty_nx = pwm_duty_cycle;
      state_nx    = (req_pwm != 16'd0) ? RUN : IDLE;
    end
    unique case (state)
      IDLE: begin
        pre_nx = 8'd0;
        cnt_nx = 8'd0;
      end
      RUN: begin
        if (state_nx == RUN) begin
          pre_nx = tick ? 8'd0 : pre_cnt + 8'd1;
          cnt_nx = tick ? pwm_cnt + 8'd1 : pwm_cnt;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    ps_nx  = load && (state_nx == RUN);
    out_nx = app_out & (~app_pwm | {16{pwm_high}});
  end

  // State, shadow config, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pre_cnt      <= 8'd0;
      pwm_cnt      <= 8'd0;
      app_out      <= 16'd0;
      app_pwm      <= 16'd0;
      app_duty     <= 8'd0;
      out          <= 16'd0;
      period_start <= 1'b0;
    end else begin
      state        <= state_nx;
      pre_cnt      <= pre_nx;
      pwm_cnt      <= cnt_nx;
      app_out      <= app_out_nx;
      app_pwm      <= app_pwm_nx;
      app_duty     <= app_duty_nx;
      out          <= out_nx;
      period_start <= ps_nx;
    end
  end

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// Bench for pwm_update_scheduler: directed steps plus random config churn.
// A phase-based reference model predicts outputs every cycle.
module tb_pwm_update_scheduler;

  localparam int P   = 13;
  localparam int PER = 256 * P;

  logic        clk;
  logic        rst_n;
  logic [7:0]  en_reg_out_7_0, en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start, update_pending, running;

  int n_assert = 0;
  int n_fail   = 0;

  bit          m_run;
  logic [39:0] m_app;
  int          m_t;
  logic [15:0] m_out;
  bit          m_ps;

  pwm_update_scheduler #(.PRESCALE(P)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en_reg_out_7_0(en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle),
    .out(out),
    .period_start(period_start),
    .update_pending(update_pending),
    .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [39:0] req();
    return {en_reg_out_15_8, en_reg_out_7_0,
            en_reg_pwm_15_8, en_reg_pwm_7_0, pwm_duty_cycle};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_app = '0; m_t = 0; m_out = '0; m_ps = 0;
  endtask

  task automatic step();
    logic [39:0] rq, napp;
    logic [15:0] nout;
    bit wrap, load, nrun, high, nps;
    int nt;
    rq   = req();
    wrap = m_run && (m_t == PER - 1);
    load = !m_run || wrap;
    napp = load ? rq : m_app;
    nrun = load ? (napp[23:8] != 16'd0) : m_run;
    nt   = (nrun && !load) ? m_t + 1 : 0;
    high = (m_app[7:0] == 8'hFF) || ((m_t / P) < int'(m_app[7:0]));
    nout = m_app[39:24] & (~m_app[23:8] | {16{high}});
    nps  = load && nrun;
    @(posedge clk);
    m_app = napp; m_run = nrun; m_t = nt; m_out = nout; m_ps = nps;
    #1;
    chk("out", 32'(out), 32'(m_out));
    chk("period_start", 32'(period_start), 32'(m_ps));
    chk("running", 32'(running), 32'(m_run));
    chk("update_pending", 32'(update_pending),
        32'(m_run && (req() != m_app)));
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_ps", 32'(period_start), 32'h0);
    chk("rst_pwm_cnt", 32'(dut.pwm_cnt), 32'h0);
    chk("rst_pre_cnt", 32'(dut.pre_cnt), 32'h0);
    repeat (2) @(posedge clk);
    #1 chk("rst_hold_out", 32'(out), 32'h0);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic wait_ps();
    int n;
    n = 0;
    while (!period_start && n < 2 * PER) begin
      step();
      n++;
    end
    chk("ps_wait", 32'(period_start), 32'h1);
  endtask

  task automatic period(input int chg, input logic [7:0] nd,
                        output int hi, output logic ps_end,
                        output logic pend);
    hi = 0;
    pend = 1'b0;
    for (int i = 0; i < PER; i++) begin
      if (i == chg) pwm_duty_cycle = nd;
      step();
      if (i == chg) pend = update_pending;
      if (out[0]) hi++;
    end
    ps_end = period_start;
  endtask

  task automatic set_cfg(input logic [15:0] o, input logic [15:0] p,
                         input logic [7:0] d);
    {en_reg_out_15_8, en_reg_out_7_0} = o;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = p;
    pwm_duty_cycle = d;
  endtask

  initial begin
    int hi, n;
    logic pse, pend;
    rst_n = 1'b0;
    set_cfg(16'hFFFF, 16'hFFFF, 8'hFF);
    model_reset();

    apply_reset();
    step();
    chk("run_edge1", 32'(running), 32'h1);
    step();
    chk("out_all_on", 32'(out), 32'hFFFF);

    set_cfg(16'h5AA5, 16'h0000, 8'h00);
    apply_reset();
    step();
    step();
    chk("idle_static_out", 32'(out), 32'h5AA5);
    chk("idle_running", 32'(running), 32'h0);
    for (int k = 0; k < 20; k++) begin
      set_cfg(16'($urandom), 16'h0, 8'($urandom));
      repeat (3) step();
    end

    set_cfg(16'hFFFF, 16'h0001, 8'd128);
    wait_ps();
    period(-1, 8'd0, hi, pse, pend);
    chk("hi_128", 32'(hi), 32'd1664);
    chk("ps_interval", 32'(pse), 32'h1);
    chk("upper_on", 32'(out[15:1]), 32'h7FFF);

    period(1000, 8'd64, hi, pse, pend);
    chk("deferred_hi", 32'(hi), 32'd1664);
    chk("pend_set", 32'(pend), 32'h1);
    chk("pend_clear", 32'(update_pending), 32'h0);
    period(-1, 8'd0, hi, pse, pend);
    chk("hi_64", 32'(hi), 32'd832);

    period(5, 8'd0, hi, pse, pend);
    chk("hi_64_again", 32'(hi), 32'd832);
    period(5, 8'd255, hi, pse, pend);
    chk("hi_duty0", 32'(hi), 32'd0);
    period(-1, 8'd0, hi, pse, pend);
    chk("hi_duty255", 32'(hi), 32'(PER));

    en_reg_pwm_7_0 = 8'h00;
    n = 0;
    while (running && n < 2 * PER) begin
      step();
      n++;
    end
    chk("back_to_idle", 32'(running), 32'h0);
    step();
    step();
    chk("idle_out", 32'(out), 32'hFFFF);

    set_cfg(16'hF0F0, 16'h8181, 8'd128);
    wait_ps();
    repeat (100 * P) step();
    chk("cnt_100", 32'(dut.pwm_cnt), 32'd100);
    apply_reset();
    step();
    chk("restart_run", 32'(running), 32'h1);

    for (int k = 0; k < 9000; k++) begin
      if ($urandom_range(0, 399) == 0) begin
        set_cfg(16'($urandom),
                ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
                8'($urandom));
        if ($urandom_range(0, 3) == 0)
          pwm_duty_cycle = $urandom_range(0, 1) ? 8'hFF : 8'h00;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
